// File: rtl/selfwrite_pkg.sv
// Shared types and sizing for the self-write byte packer.
// Imported by selfwrite_packer for its FSM encoding and counter widths.
package selfwrite_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        GAP     = 2'd3
    } sw_state_t;

    localparam int SW_WORD_BYTES = 4;
    localparam int SW_CNT_W      = 4;
    localparam int SW_WCNT_W     = 16;

endpackage

// File: rtl/selfwrite_packer.sv
// Packs a byte stream MSB-first into 32-bit words and paces them onto the
// fabric self-write port with setup / strobe / gap timing.
module selfwrite_packer
    import selfwrite_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [31:0]          SelfWriteData,
    output logic                 SelfWriteStrobe,
    output logic [SW_WCNT_W-1:0] word_count,
    output logic                 done
);

    localparam logic [SW_CNT_W-1:0] SETUP_LOAD =
        SW_CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
    localparam logic [SW_CNT_W-1:0] GAP_LOAD =
        SW_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sw_state_t            state_reg, state_next;
    logic [1:0]           idx_reg, idx_next;
    logic [31:0]          asm_reg, asm_next;
    logic [31:0]          data_reg, data_next;
    logic [SW_CNT_W-1:0]  cnt_reg, cnt_next;
    logic                 last_reg, last_next;
    logic [SW_WCNT_W-1:0] word_count_reg, word_count_next;
    logic                 done_reg, done_next;

    logic                 accept;
    logic [31:0]          packed_word;

    assign accept = s_valid && (state_reg == COLLECT);

    // Lanes below idx come from the assembly register, lane idx takes the
    // incoming byte, and lanes above it are zero so short words pad cleanly.
    for (genvar gi = 0; gi < SW_WORD_BYTES; gi++) begin : g_lane
        assign packed_word[31-8*gi -: 8] =
            (idx_reg > 2'(gi))  ? asm_reg[31-8*gi -: 8] :
            (idx_reg == 2'(gi)) ? s_data : 8'h00;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg      <= COLLECT;
            idx_reg        <= '0;
            asm_reg        <= '0;
            data_reg       <= '0;
            cnt_reg        <= '0;
            last_reg       <= 1'b0;
            word_count_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            asm_reg        <= asm_next;
            data_reg       <= data_next;
            cnt_reg        <= cnt_next;
            last_reg       <= last_next;
            word_count_reg <= word_count_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        asm_next        = asm_reg;
        data_next       = data_reg;
        cnt_next        = cnt_reg;
        last_next       = last_reg;
        word_count_next = word_count_reg;
        done_next       = done_reg;

        case (state_reg)
            COLLECT: begin
                if (accept) begin
                    asm_next  = packed_word;
                    done_next = 1'b0;
                    if (idx_reg == 2'd3 || s_last) begin
                        data_next  = packed_word;
                        last_next  = s_last;
                        idx_next   = '0;
                        cnt_next   = SETUP_LOAD;
                        state_next = (SETUP_CYCLES == 0) ? STROBE : SETUP;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = STROBE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            STROBE: begin
                if (!(&word_count_reg)) begin
                    word_count_next = word_count_reg + SW_WCNT_W'(1);
                end
                if (last_reg) begin
                    done_next = 1'b1;
                end
                cnt_next   = GAP_LOAD;
                state_next = (GAP_CYCLES == 0) ? COLLECT : GAP;
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = COLLECT;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    assign s_ready         = (state_reg == COLLECT);
    assign SelfWriteStrobe = (state_reg == STROBE);
    assign SelfWriteData   = data_reg;
    assign word_count      = word_count_reg;
    assign done            = done_reg;

endmodule

// File: doc/selfwrite_packer.md
# selfwrite_packer

Upstream feeder for the fabric configuration port. It accepts the bitstream as a byte stream over a valid/ready handshake and packs each group of four bytes MSB-first into a 32-bit word. It then drives `SelfWriteData`/`SelfWriteStrobe` with the setup/strobe/gap pacing the fabric's self-write path requires. It sits between the bitstream source (ROM reader, SPI or UART receiver) and `eFPGA_top`.

## Interface
- `SETUP_CYCLES`, default 2: cycles `SelfWriteData` is stable before the strobe. Legal range 0..15.
- `GAP_CYCLES`, default 2: idle cycles after the strobe before the next byte is accepted. Legal range 0..15.
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_data`  in  8  bitstream byte.
- `s_valid`  in  1  byte valid.
- `s_last`  in  1  final byte of the bitstream; qualified by `s_valid`.
- `s_ready`  out  1  byte accepted on an edge where `s_valid && s_ready`.
- `SelfWriteData`  out  32  packed configuration word; connects straight to the fabric port.
- `SelfWriteStrobe`  out  1  one-cycle write strobe.
- `word_count`  out  16  words strobed since reset; saturates at 0xFFFF.
- `done`  out  1  sticky; set when the word containing the `s_last` byte has been strobed.

## Operation
- FSM states: COLLECT, SETUP, STROBE, GAP. Reset state is COLLECT.
- `s_ready` = (state == COLLECT). It is a pure decode of registered state with no combinational path from `s_valid`.
- **COLLECT:** a 2-bit byte index `idx` starts at 0.
  - Each accepted byte is written into lane `31-8*idx : 24-8*idx` of the assembly register. The first byte lands in bits 31:24.
  - When the accepted byte has `idx==3`, or `s_last` is set: lanes not yet written are forced to 0x00, the assembly word is loaded into `SelfWriteData` on that same edge, `idx` returns to 0, and the FSM goes to SETUP.
  - If `SETUP_CYCLES==0`, the FSM goes directly to STROBE.
- **SETUP:** a down-counter runs for `SETUP_CYCLES` cycles, then the FSM moves to STROBE.
- **STROBE:** `SelfWriteStrobe`=1 for exactly one cycle, and `word_count` increments (saturating). If the word carried `s_last`, `done` is set. The FSM then moves to GAP, or to COLLECT if `GAP_CYCLES==0`.
- **GAP:** counter runs for `GAP_CYCLES` cycles, then COLLECT.
- `SelfWriteData` holds its value until the next word is loaded. It never changes while the strobe is high or during SETUP.
- `done` is cleared by the first byte accepted after it was set, which starts a new bitstream. `word_count` is not cleared except by reset.
- **Reset, asserted at any time:** FSM goes to COLLECT, `idx`=0, the partial word is discarded, and all outputs clear.
- **Reset values:** `SelfWriteData`=0, `SelfWriteStrobe`=0, `word_count`=0, `done`=0, `s_ready`=1.
- `s_valid` while `s_ready`=0 is ignored; the upstream must hold the byte.
- If `s_last` arrives with `idx==3`, this is an ordinary full word with `done` set at its strobe.

## Timing
- The 4th byte (or the `s_last` byte) is accepted at edge t. `SelfWriteData` is valid after edge t.
- `SelfWriteStrobe` rises at edge t+`SETUP_CYCLES` and falls at edge t+`SETUP_CYCLES`+1. The fabric therefore samples data that has been stable for `SETUP_CYCLES`+1 edges.
- `s_ready` rises at edge t+`SETUP_CYCLES`+1+`GAP_CYCLES`.
- Minimum period per word with continuous `s_valid`: 4+`SETUP_CYCLES`+1+`GAP_CYCLES` cycles, which is 9 at the defaults.
- `word_count` and `done` update on the same edge the strobe falls.

## Structure
- Package `selfwrite_pkg`:
  - state enum `sw_state_t` (COLLECT, SETUP, STROBE, GAP);
  - constants `SW_WORD_BYTES`=4, `SW_CNT_W`=4 (pacing counter width), `SW_WCNT_W`=16.
- Single module with no sub-module. The pacing counter is shared between SETUP and GAP and lives inline with the FSM.

## Test plan
- **Full word:** bytes DE, AD, BE, EF with `s_valid` held high. Required: `SelfWriteData`=0xDEADBEEF after the 4th accept edge t; strobe high only between t+2 and t+3; `s_ready` low from t to t+5; `word_count`=1.
- **Back-to-back:** 8 bytes 01..08 streamed continuously. Required: words 0x01020304 then 0x05060708; strobes exactly 9 cycles apart; `word_count`=2.
- **Short last word:** bytes AA, BB with `s_last` on BB. Required: `SelfWriteData`=0xAABB0000, one strobe, `done`=1. The next accepted byte clears `done`.
- **Backpressure:** `s_valid` held high during SETUP/GAP with a changing `s_data`. Required: no byte consumed while `s_ready`=0; packed words match only the handshaken bytes.
- **Reset mid-word:** 2 bytes accepted, then `reset` pulsed asynchronously between edges. Required: all outputs 0 immediately; the next 4 bytes 11, 22, 33, 44 give 0x11223344.
- **Pacing parameters:** `SETUP_CYCLES`=0, `GAP_CYCLES`=0. Required: strobe on the edge after the 4th accept; `s_ready` back one cycle later; period 5 cycles. Additionally, `word_count` saturation at 0xFFFF, checked by forcing the counter to 0xFFFE.
